// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, MEM-stage branch flush, dmem freeze watchdog
// Optional feature macro: HAZARD_STATS_EN (adds stall_cnt / flush_cnt outputs)
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MAX_FREEZE = 255,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic             freeze_timeout,
  output logic [1:0]       state
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Freeze counter must be able to hold MAX_FREEZE+1 (the saturation value).
  localparam int FC_W = $clog2(MAX_FREEZE + 2);
  localparam logic [FC_W-1:0] FC_SAT = FC_W'(MAX_FREEZE + 1);
  localparam logic [FC_W-1:0] FC_LIM = FC_W'(MAX_FREEZE);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOADSTALL = 2'd1,
    FLUSH     = 2'd2,
    FREEZE    = 2'd3
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic [FC_W-1:0] freeze_cnt;
  logic            load_use;
  logic            lu_masked;

  // Raw load-use detection; register 0 never creates a dependency.
  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // The cycle after a bubble or flush, ID/EX no longer holds the load, so suppress re-stall.
  assign lu_masked = (cur_state == LOADSTALL) || (cur_state == FLUSH);

  assign state = cur_state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next state and Mealy enables; priority busy > branch > load-use, FREEZE exits as RUN.
  always_comb begin
    nxt_state   = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      nxt_state = RUN;
    end else if (dmem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      nxt_state   = FREEZE;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      nxt_state   = FLUSH;
    end else if (load_use && !lu_masked) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      nxt_state   = LOADSTALL;
    end
  end

  // Consecutive frozen-cycle counter, saturating one past the tolerance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_cnt <= '0;
    end else if (dmem_busy) begin
      if (freeze_cnt != FC_SAT) begin
        freeze_cnt <= freeze_cnt + FC_W'(1);
      end
    end else begin
      freeze_cnt <= '0;
    end
  end

  // Sticky watchdog flag: sets on the busy cycle that brings the count to MAX_FREEZE+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_timeout <= 1'b0;
    end else if (dmem_busy && (freeze_cnt >= FC_LIM)) begin
      freeze_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Event counters for bubbles and branch flushes; wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(idex_bubble);
      flush_cnt <= flush_cnt + CNT_W'(ifid_flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-level behavioural model
module tb_hazard_ctrl;

  localparam int MAXF  = 4;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0, dmem_busy = 1'b0;
  logic       pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic       pipe_freeze, freeze_timeout;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.REG_W(5), .MAX_FREEZE(MAXF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_freeze(pipe_freeze), .freeze_timeout(freeze_timeout), .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observed outputs packed: pc, ifid_w, bubble, ifid_f, idex_f, exmem_f, freeze, timeout, state
  wire [9:0] act = {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
                    pipe_freeze, freeze_timeout, state};

  // Behavioural model: what the controller did last cycle, how long memory has been busy, sticky timeout.
  logic [1:0] m_last;     // 0 nothing, 1 bubbled, 2 flushed, 3 frozen
  int         m_run;      // consecutive busy cycles so far (unbounded)
  logic       m_to;
  int         m_stall, m_flush;

  function automatic logic [1:0] model_action();
    logic dep;
    dep = ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    if (dmem_busy) return 2'd3;
    if (mem_branch_taken) return 2'd2;
    if (dep && !(m_last == 2'd1 || m_last == 2'd2)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [9:0] model_out();
    if (rst) return {2'b11, 6'b0, 2'b00};
    case (model_action())
      2'd3:    return {2'b00, 4'b0000, 1'b1, m_to, m_last};
      2'd2:    return {2'b11, 1'b0, 3'b111, 1'b0, m_to, m_last};
      2'd1:    return {2'b00, 1'b1, 3'b000, 1'b0, m_to, m_last};
      default: return {2'b11, 5'b0, m_to, m_last};
    endcase
  endfunction

  task automatic model_step();
    logic [1:0] a;
    a = model_action();
    if (a == 2'd1) m_stall = (m_stall + 1) % (1 << CNT_W);
    if (a == 2'd2) m_flush = (m_flush + 1) % (1 << CNT_W);
    m_run  = dmem_busy ? m_run + 1 : 0;
    if (m_run > MAXF) m_to = 1'b1;
    m_last = a;
  endtask

  task automatic model_reset();
    m_last = 2'd0; m_run = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic set_in(input logic b, input logic br, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic u);
    dmem_busy = b; mem_branch_taken = br; ex_memread = mr; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rt = u;
  endtask

  // Advance to the next cycle: model follows the clock edge, inputs then change 1 ns later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b1;
    set_in(1, 1, 1, 5'd2, 5'd2, 5'd2, 1);
    model_reset();
    @(negedge clk);
    e = {2'b11, 6'b0, 2'b00};
    n_checks++;
    if (act !== e) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", act, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [9:0] e;
    // lw $2 in EX, ID reads $2 as rs; held for two cycles, then cleared
    for (int i = 0; i < 4; i++) begin
      if (i < 2) set_in(0, 0, 1, 5'd2, 5'd2, 5'd7, 0); else set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = model_out();
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL load_use cyc%0d: got %b expected %b", i, act, e); end
      if (i == 0) begin
        n_checks++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
          n_fail++; $display("FAIL load_use_same_cycle: got %b expected 001", {pc_write, ifid_write, idex_bubble});
        end
      end
      if (i == 1) begin
        n_checks++;
        if (state !== 2'd1 || idex_bubble !== 1'b0) begin
          n_fail++; $display("FAIL load_use_single_bubble: got state %0d bubble %b expected 1 0", state, idex_bubble);
        end
      end
      tick();
    end
  endtask

  task automatic test_no_stall();
    logic [9:0] e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_in(0, 0, 1, 5'd0, 5'd0, 5'd0, 1);   // load into $0
        1: set_in(0, 0, 1, 5'd2, 5'd5, 5'd2, 0);   // rt match, rt unused
        default: set_in(0, 0, 1, 5'd3, 5'd5, 5'd4, 1); // no match
      endcase
      @(negedge clk);
      e = model_out();
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL no_stall cyc%0d: got %b expected %b", i, act, e); end
      n_checks++;
      if (idex_bubble !== 1'b0) begin n_fail++; $display("FAIL no_stall_bubble cyc%0d: got %b expected 0", i, idex_bubble); end
      tick();
    end
  endtask

  task automatic test_branch_overrides();
    logic [9:0] e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_in(0, 1, 1, 5'd6, 5'd1, 5'd6, 1); else set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = model_out();
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL branch cyc%0d: got %b expected %b", i, act, e); end
      if (i == 0) begin
        n_checks++;
        if ({ifid_flush, idex_flush, exmem_flush, idex_bubble, pc_write} !== 5'b11101) begin
          n_fail++; $display("FAIL branch_over_loaduse: got %b expected 11101",
                             {ifid_flush, idex_flush, exmem_flush, idex_bubble, pc_write});
        end
      end
      if (i == 1) begin
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL branch_state: got %0d expected 2", state); end
      end
      tick();
    end
  endtask

  task automatic test_freeze_then_bubble();
    logic [9:0] e;
    logic [1:0] want_state [6] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3)      set_in(1, 0, 1, 5'd4, 5'd4, 5'd0, 0);
      else if (i < 5) set_in(0, 0, 1, 5'd4, 5'd4, 5'd0, 0);
      else            set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = model_out();
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL freeze_bubble cyc%0d: got %b expected %b", i, act, e); end
      n_checks++;
      if (state !== want_state[i]) begin
        n_fail++; $display("FAIL freeze_bubble_state cyc%0d: got %0d expected %0d", i, state, want_state[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) set_in(1, 0, 0, 0, 0, 0, 0); else set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      e = model_out();
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL timeout cyc%0d: got %b expected %b", i, act, e); end
      // after the 5th busy edge the flag must be up (i counts busy edges already taken)
      n_checks++;
      if (freeze_timeout !== (i >= 5)) begin
        n_fail++; $display("FAIL timeout_flag cyc%0d: got %b expected %b", i, freeze_timeout, (i >= 5));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_freeze();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (state !== 2'd0 || freeze_timeout !== 1'b0 || pipe_freeze !== 1'b0 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got state %0d to %b frz %b pc %b expected 0 0 0 1",
                         state, freeze_timeout, pipe_freeze, pc_write);
    end
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL async_reset_stats: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [9:0] e;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1));
      if (i >= 200 && i < 210) dmem_busy = 1'b1;   // one long freeze to trip the watchdog
      @(negedge clk);
      e = model_out();
      n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL random cyc%0d: got %b expected %b", i, act, e); end
`ifdef HAZARD_STATS_EN
      n_checks++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        n_fail++; $display("FAIL random_stats cyc%0d: got %0d/%0d expected %0d/%0d",
                           i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
      if (i == 300) begin
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (act !== {2'b11, 6'b0, 2'b00}) begin
          n_fail++; $display("FAIL random_reset: got %b expected 1100000000", act);
        end
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_overrides();
    test_freeze_then_bubble();
    test_timeout();
    test_reset_mid_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
